// File: rtl/memwrite_checker_if.sv
// Bundles expected-entry config, run control, the store strobe and checker status.
// Latency: none; plain wires between the stimulus side and memwrite_checker.
// Backpressure: none; all signals are level/strobe sampled on the clock edge.
interface memwrite_checker_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MC_W  = $clog2(DEPTH + 1);

   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic [MC_W-1:0]   cfg_count;
   logic              start;
   logic              mem_write;
   logic [ADDR_W-1:0] data_adr;
   logic [DATA_W-1:0] write_data;
   logic              busy;
   logic              done;
   logic              pass;
   logic              fail;
   logic              timeout;
   logic [MC_W-1:0]   match_count;
   logic [7:0]        err_count;
   logic [ADDR_W-1:0] err_adr;
   logic [DATA_W-1:0] err_data;

   modport master (
      output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
             mem_write, data_adr, write_data,
      input  busy, done, pass, fail, timeout, match_count, err_count,
             err_adr, err_data
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
             mem_write, data_adr, write_data,
      output busy, done, pass, fail, timeout, match_count, err_count,
             err_adr, err_data
   );
endinterface

// File: rtl/memwrite_checker.sv
// Checks processor stores against a table of expected (address, data) writes.
// Latency: status outputs are registered, updating one cycle after the sampling edge.
// Backpressure: none; every store in RUN is evaluated on the edge it is seen.
module memwrite_checker #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       DEPTH       = 4,
   parameter logic [ADDR_W-1:0] IGNORE_ADDR = 96,
   parameter bit                ORDERED     = 1'b1,
   parameter bit                STOP_ON_ERR = 1'b1,
   parameter int unsigned       TIMEOUT_CYC = 1000
) (
   input logic               clk,
   input logic               reset,
   memwrite_checker_if.slave mw
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MC_W  = $clog2(DEPTH + 1);
   localparam int unsigned CYC_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [MC_W-1:0]  DEPTH_MC = MC_W'(DEPTH);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t            r_state;
   logic              r_busy, r_done, r_pass, r_fail, r_timeout;
   logic [MC_W-1:0]   r_mc;
   logic [MC_W-1:0]   r_cnt;
   logic [7:0]        r_err_cnt;
   logic [ADDR_W-1:0] r_err_adr;
   logic [DATA_W-1:0] r_err_data;
   logic [DEPTH-1:0]  r_hit;
   logic [CYC_W-1:0]  r_cyc;
   logic [ADDR_W-1:0] r_ent_addr [DEPTH];
   logic [DATA_W-1:0] r_ent_data [DEPTH];

   logic              w_store;
   logic              w_hit_vld;
   logic [IDX_W-1:0]  w_hit_idx;
   logic              w_match;
   logic              w_err;
   logic [MC_W-1:0]   w_mc_nxt;
   logic [7:0]        w_err_nxt;
   logic              w_complete;
   logic              w_tmo;

   assign mw.busy        = r_busy;
   assign mw.done        = r_done;
   assign mw.pass        = r_pass;
   assign mw.fail        = r_fail;
   assign mw.timeout     = r_timeout;
   assign mw.match_count = r_mc;
   assign mw.err_count   = r_err_cnt;
   assign mw.err_adr     = r_err_adr;
   assign mw.err_data    = r_err_data;

   // Classify this cycle's store: which entry it hits (if any) and the resulting counts.
   always_comb begin
      w_store   = mw.mem_write && (mw.data_adr != IGNORE_ADDR);
      w_hit_vld = 1'b0;
      w_hit_idx = '0;
      if (ORDERED) begin
         // Only the entry at the current match position may be hit.
         w_hit_idx = r_mc[IDX_W-1:0];
         w_hit_vld = (r_mc < r_cnt) && (r_mc < DEPTH_MC) && !r_hit[w_hit_idx] &&
                     (r_ent_addr[w_hit_idx] == mw.data_adr) &&
                     (r_ent_data[w_hit_idx] == mw.write_data);
      end else begin
         // Scan downwards so the lowest-index unhit candidate wins.
         for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (!r_hit[k] && (MC_W'(k) < r_cnt) &&
                (r_ent_addr[k] == mw.data_adr) && (r_ent_data[k] == mw.write_data)) begin
               w_hit_vld = 1'b1;
               w_hit_idx = IDX_W'(k);
            end
         end
      end
      w_match    = w_store && w_hit_vld;
      w_err      = w_store && !w_hit_vld;
      w_mc_nxt   = r_mc + MC_W'(w_match);
      w_err_nxt  = (w_err && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
      w_complete = (w_mc_nxt == r_cnt);
      w_tmo      = (r_cyc == CYC_LAST);
   end

   // Expected-entry table; frozen while a run is in progress, not reset.
   always_ff @(posedge clk) begin
      if (mw.cfg_we && (r_state != S_RUN)) begin
         r_ent_addr[mw.cfg_idx] <= mw.cfg_addr;
         r_ent_data[mw.cfg_idx] <= mw.cfg_data;
      end
   end

   // Run-control FSM with its registered status flags and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_timeout  <= 1'b0;
         r_mc       <= '0;
         r_cnt      <= '0;
         r_err_cnt  <= '0;
         r_err_adr  <= '0;
         r_err_data <= '0;
         r_hit      <= '0;
         r_cyc      <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_cyc <= r_cyc + CYC_W'(1);
               if (w_match) begin
                  r_mc             <= w_mc_nxt;
                  r_hit[w_hit_idx] <= 1'b1;
               end
               if (w_err) begin
                  r_err_cnt <= w_err_nxt;
                  if (r_err_cnt == 8'd0) begin
                     r_err_adr  <= mw.data_adr;
                     r_err_data <= mw.write_data;
                  end
               end
               // Completion outranks an error stop, which outranks the timeout.
               if (w_complete) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                  if (w_err_nxt == 8'd0) begin
                     r_state <= S_PASS;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                  end
               end else if (STOP_ON_ERR && w_err) begin
                  r_state <= S_FAIL;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_fail  <= 1'b1;
               end else if (w_tmo) begin
                  r_state   <= S_FAIL;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_fail    <= 1'b1;
                  r_timeout <= 1'b1;
               end
            end
            default: begin
               if (mw.start) begin
                  r_state    <= S_RUN;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_pass     <= 1'b0;
                  r_fail     <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_cnt      <= mw.cfg_count;
                  r_mc       <= '0;
                  r_err_cnt  <= '0;
                  r_err_adr  <= '0;
                  r_err_data <= '0;
                  r_hit      <= '0;
                  r_cyc      <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memwrite_checker.sv
// Drives three checker variants (ordered/stop, ordered/continue, unordered/continue)
// with a shared stimulus stream and compares each against its own reference model.
// No backpressure; inputs change #1 after the rising edge, outputs are read there too.
`timescale 1ns/1ps
module tb_memwrite_checker;
   localparam logic [2:0] ORD_MASK  = 3'b011;
   localparam logic [2:0] STOP_MASK = 3'b001;
   localparam int P_IDLE = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3;

   typedef struct packed {
      logic        busy, done, pass, fail, tmo;
      logic [2:0]  mc;
      logic [7:0]  err;
      logic [31:0] adr;
      logic [31:0] dat;
   } stat_t;

   typedef struct {
      logic [31:0] ea, ed, sa, sd;
      stat_t       want;
   } vec_t;

   logic        clk = 1'b0, reset = 1'b0;
   logic        cfg_we = 1'b0, start = 1'b0, mem_write = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0, cfg_data = '0, data_adr = '0, write_data = '0;
   logic [2:0]  cfg_count = '0;
   stat_t [2:0] dut_st;
   int          n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      memwrite_checker_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus ();
      assign bus.cfg_we     = cfg_we;
      assign bus.cfg_idx    = cfg_idx;
      assign bus.cfg_addr   = cfg_addr;
      assign bus.cfg_data   = cfg_data;
      assign bus.cfg_count  = cfg_count;
      assign bus.start      = start;
      assign bus.mem_write  = mem_write;
      assign bus.data_adr   = data_adr;
      assign bus.write_data = write_data;
      memwrite_checker #(
         .ADDR_W(32), .DATA_W(32), .DEPTH(4), .IGNORE_ADDR(32'd96),
         .ORDERED(ORD_MASK[g]), .STOP_ON_ERR(STOP_MASK[g]),
         .TIMEOUT_CYC((g == 0) ? 20 : 1000)
      ) u_dut (
         .clk(clk), .reset(reset), .mw(bus)
      );
      assign dut_st[g] = '{bus.busy, bus.done, bus.pass, bus.fail, bus.timeout,
                           bus.match_count, bus.err_count, bus.err_adr, bus.err_data};
   end

   // ---------------- reference model: remaining-entry lists per variant ----------------
   int          m_phase [3];
   logic [63:0] m_tab   [3][4];
   logic [63:0] m_rem   [3][4];
   int          m_nrem[3], m_cnt[3], m_match[3], m_err[3], m_cyc[3];
   logic [31:0] m_eadr[3], m_edat[3];
   bit          m_tf[3];

   function automatic int tmo_of(input int c);
      return (c == 0) ? 20 : 1000;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_phase[c] = P_IDLE; m_nrem[c] = 0; m_cnt[c] = 0; m_match[c] = 0;
         m_err[c] = 0; m_cyc[c] = 0; m_eadr[c] = '0; m_edat[c] = '0; m_tf[c] = 1'b0;
      end
   endtask

   task automatic model_step(input int c);
      logic [63:0] s;
      bit          is_err;
      int          j;
      s = {data_adr, write_data};
      if (m_phase[c] != P_RUN) begin
         if (cfg_we) m_tab[c][cfg_idx] = {cfg_addr, cfg_data};
         if (start) begin
            m_phase[c] = P_RUN; m_cnt[c] = int'(cfg_count); m_nrem[c] = 0;
            for (int k = 0; k < 4; k++)
               if (k < m_cnt[c]) begin m_rem[c][m_nrem[c]] = m_tab[c][k]; m_nrem[c]++; end
            m_match[c] = 0; m_err[c] = 0; m_cyc[c] = 0;
            m_eadr[c] = '0; m_edat[c] = '0; m_tf[c] = 1'b0;
         end
      end else begin
         m_cyc[c]++;
         is_err = 1'b0;
         if (mem_write && data_adr != 32'd96) begin
            j = -1;
            if (ORD_MASK[c]) begin
               if (m_nrem[c] > 0 && m_rem[c][0] == s) j = 0;
            end else begin
               for (int k = m_nrem[c] - 1; k >= 0; k--) if (m_rem[c][k] == s) j = k;
            end
            if (j >= 0) begin
               for (int k = j; k < m_nrem[c] - 1; k++) m_rem[c][k] = m_rem[c][k+1];
               m_nrem[c]--;
               m_match[c]++;
            end else begin
               if (m_err[c] == 0) begin m_eadr[c] = data_adr; m_edat[c] = write_data; end
               if (m_err[c] < 255) m_err[c]++;
               is_err = 1'b1;
            end
         end
         if (m_match[c] == m_cnt[c])              m_phase[c] = (m_err[c] == 0) ? P_PASS : P_FAIL;
         else if (STOP_MASK[c] && is_err)         m_phase[c] = P_FAIL;
         else if (m_cyc[c] == tmo_of(c)) begin    m_phase[c] = P_FAIL; m_tf[c] = 1'b1; end
      end
   endtask

   function automatic stat_t model_stat(input int c);
      stat_t s;
      s.busy = (m_phase[c] == P_RUN);
      s.done = (m_phase[c] == P_PASS) || (m_phase[c] == P_FAIL);
      s.pass = (m_phase[c] == P_PASS);
      s.fail = (m_phase[c] == P_FAIL);
      s.tmo  = m_tf[c];
      s.mc   = 3'(m_match[c]);
      s.err  = 8'(m_err[c]);
      s.adr  = m_eadr[c];
      s.dat  = m_edat[c];
      return s;
   endfunction

   function automatic stat_t mk(input bit b, d, p, f, t, input int mc, err,
                                input logic [31:0] a, dt);
      stat_t s;
      s = '{b, d, p, f, t, 3'(mc), 8'(err), a, dt};
      return s;
   endfunction

   function automatic string fmt(input stat_t s);
      return $sformatf("busy=%0b done=%0b pass=%0b fail=%0b timeout=%0b match=%0d err=%0d err_adr=%0h err_data=%0h",
                       s.busy, s.done, s.pass, s.fail, s.tmo, s.mc, s.err, s.adr, s.dat);
   endfunction

   task automatic chk(input string name, input int c, input stat_t want);
      n_assert++;
      if (dut_st[c] !== want) begin
         n_fail++;
         $display("FAIL %s [dut%0d] got {%s} required {%s}", name, c, fmt(dut_st[c]), fmt(want));
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      for (int c = 0; c < 3; c++) model_step(c);
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) chk("model", c, model_stat(c));
   endtask

   task automatic load(input int idx, input logic [31:0] a, d);
      cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_start(input int cnt);
      start = 1'b1; cfg_count = 3'(cnt);
      tick();
      start = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, d);
      mem_write = 1'b1; data_adr = a; write_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      #1;
      for (int c = 0; c < 3; c++) chk("reset_async", c, model_stat(c));
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic [31:0] ea [4];
      logic [31:0] ed [4];
      int          sel, j;

      tbl[0] = '{32'd100, 32'd7, 32'd100, 32'd7, mk(0,1,1,0,0, 1,0, 32'd0,   32'd0)};
      tbl[1] = '{32'd100, 32'd7, 32'd100, 32'd8, mk(0,1,0,1,0, 0,1, 32'd100, 32'd8)};
      tbl[2] = '{32'd100, 32'd7, 32'd104, 32'd7, mk(0,1,0,1,0, 0,1, 32'd104, 32'd7)};
      tbl[3] = '{32'd0,   32'd0, 32'd0,   32'd0, mk(0,1,1,0,0, 1,0, 32'd0,   32'd0)};
      tbl[4] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                 mk(0,1,1,0,0, 1,0, 32'd0, 32'd0)};
      tbl[5] = '{32'd200, 32'd5, 32'd96,  32'd5, mk(1,0,0,0,0, 0,0, 32'd0,   32'd0)};

      // reset state and hold in IDLE after release
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) chk("reset_state", c, '0);
      reset = 1'b1;
      tick(); tick();
      for (int c = 0; c < 3; c++) chk("idle_hold", c, '0);

      // single-store vectors on the ordered/stop variant
      for (int i = 0; i < 6; i++) begin
         load(0, tbl[i].ea, tbl[i].ed);
         do_start(1);
         do_store(tbl[i].sa, tbl[i].sd);
         chk($sformatf("vec%0d", i), 0, tbl[i].want);
      end
      do_reset();

      // ignored address then matching store
      load(0, 32'd100, 32'd7);
      do_start(1);
      do_store(32'd96, 32'd3);
      chk("ignore_addr", 0, mk(1,0,0,0,0, 0,0, 32'd0, 32'd0));
      do_store(32'd100, 32'd7);
      chk("ordered_pass", 0, mk(0,1,1,0,0, 1,0, 32'd0, 32'd0));

      // out-of-order pair: ordered variants error, unordered passes
      load(0, 32'd100, 32'd7);
      load(1, 32'd104, 32'd9);
      do_start(2);
      do_store(32'd104, 32'd9);
      chk("stop_on_err", 0, mk(0,1,0,1,0, 0,1, 32'd104, 32'd9));
      do_store(32'd100, 32'd7);
      chk("cont_mid", 1, mk(1,0,0,0,0, 1,1, 32'd104, 32'd9));
      chk("unordered_pass", 2, mk(0,1,1,0,0, 2,0, 32'd0, 32'd0));
      do_store(32'd104, 32'd9);
      chk("cont_fail_at_end", 1, mk(0,1,0,1,0, 2,1, 32'd104, 32'd9));

      // unordered: repeat of an already-hit entry is an error
      do_start(2);
      do_store(32'd104, 32'd9);
      do_store(32'd104, 32'd9);
      chk("unord_repeat_err", 2, mk(1,0,0,0,0, 1,1, 32'd104, 32'd9));
      do_store(32'd100, 32'd7);
      chk("unord_fail_end", 2, mk(0,1,0,1,0, 2,1, 32'd104, 32'd9));

      // timeout exactly 20 cycles after entering RUN
      load(0, 32'd100, 32'd7);
      do_start(1);
      repeat (19) tick();
      chk("pre_timeout", 0, mk(1,0,0,0,0, 0,0, 32'd0, 32'd0));
      tick();
      chk("timeout", 0, mk(0,1,0,1,1, 0,0, 32'd0, 32'd0));

      // reset in mid-RUN, then a count-0 run
      load(0, 32'd100, 32'd7);
      load(1, 32'd104, 32'd9);
      do_start(2);
      do_store(32'd100, 32'd7);
      chk("one_match", 0, mk(1,0,0,0,0, 1,0, 32'd0, 32'd0));
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_midrun", 0, '0);
      for (int c = 1; c < 3; c++) chk("reset_midrun_model", c, model_stat(c));
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("idle_after_reset", 0, '0);
      do_start(0);
      chk("count0_run", 0, mk(1,0,0,0,0, 0,0, 32'd0, 32'd0));
      tick();
      chk("count0_pass", 0, mk(0,1,1,0,0, 0,0, 32'd0, 32'd0));

      // error count saturation on the continuing ordered variant
      load(0, 32'd100, 32'd7);
      do_start(1);
      repeat (300) do_store(32'd200, 32'd1);
      chk("err_saturate", 1, mk(1,0,0,0,0, 0,255, 32'd200, 32'd1));
      do_store(32'd100, 32'd7);
      chk("err_saturate_end", 1, mk(0,1,0,1,0, 1,255, 32'd200, 32'd1));

      // randomized runs against the model
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(0, 7) == 0) do_reset();
         for (int i = 0; i < 4; i++) begin
            ea[i] = 32'(96 + 4 * $urandom_range(0, 3));
            ed[i] = 32'($urandom_range(0, 3));
            load(i, ea[i], ed[i]);
         end
         do_start(int'($urandom_range(0, 4)));
         for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
               j = int'($urandom_range(0, 3));
               mem_write = 1'b1; data_adr = ea[j]; write_data = ed[j];
            end else if (sel < 7) begin
               mem_write = 1'b1;
               data_adr = 32'(96 + 4 * $urandom_range(0, 3));
               write_data = 32'($urandom_range(0, 3));
            end
            start = ($urandom_range(0, 19) == 0);
            cfg_count = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) begin
               cfg_we = 1'b1; cfg_idx = 2'($urandom_range(0, 3));
               cfg_addr = 32'(96 + 4 * $urandom_range(0, 3));
               cfg_data = 32'($urandom_range(0, 3));
            end
            tick();
            mem_write = 1'b0; start = 1'b0; cfg_we = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/memwrite_checker.md
MEMWRITE_CHECKER -- requirements
Module: memwrite_checker

Interface
REQ-001 Parameters, one per line:
- ADDR_W, 32, data-address width.
- DATA_W, 32, write-data width.
- DEPTH, 4, number of expected-write entries (min 1).
- IGNORE_ADDR, 96, address whose writes are never checked.
- ORDERED, 1: 1 = entries must match in index order; 0 = any order.
- STOP_ON_ERR, 1: 1 = FAIL on first error; 0 = run to completion, counting errors.
- TIMEOUT_CYC, 1000, maximum RUN cycles before FAIL.

REQ-002 Ports, one per line:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low.
- cfg_we, in, 1: write expected entry.
- cfg_idx, in, clog2(DEPTH): entry index.
- cfg_addr, in, ADDR_W: expected address.
- cfg_data, in, DATA_W: expected data.
- cfg_count, in, clog2(DEPTH+1): number of valid entries, latched at start.
- start, in, 1: begin a check run.
- mem_write, in, 1: processor store strobe.
- data_adr, in, ADDR_W: store address.
- write_data, in, DATA_W: store data.
- busy, out, 1: state is RUN.
- done, out, 1: state is PASS or FAIL.
- pass, out, 1: state is PASS.
- fail, out, 1: state is FAIL.
- timeout, out, 1: FAIL was caused by timeout.
- match_count, out, clog2(DEPTH+1): entries matched so far.
- err_count, out, 8: mismatching stores; saturates at 255.
- err_adr, out, ADDR_W: address of the first mismatching store.
- err_data, out, DATA_W: data of the first mismatching store.

Function
REQ-003 States SHALL be IDLE, RUN, PASS and FAIL, and all outputs SHALL be registered.
REQ-004 cfg_we SHALL write cfg_addr and cfg_data into entry cfg_idx in IDLE, PASS or FAIL, and SHALL be ignored in RUN.
REQ-005 start in any state other than RUN SHALL go to RUN next cycle, latch cfg_count, and clear the following: match_count, err_count, err_adr, err_data, timeout, the hit bits and the cycle counter.
REQ-006 start while in RUN SHALL be ignored.
REQ-007 A store SHALL be sampled only on a rising edge in RUN with mem_write=1; stores are not checked in the start cycle.
REQ-008 A store with data_adr==IGNORE_ADDR SHALL have no effect.
REQ-009 ORDERED=1: a store SHALL match when address and data equal entry[match_count]; a match increments match_count, and anything else is an error.
REQ-010 ORDERED=0: a store SHALL match the lowest-index unhit entry with equal address and data, setting its hit bit and incrementing match_count. A store that equals only already-hit entries is an error.
REQ-011 The first error of a run SHALL capture err_adr/err_data; every error SHALL increment err_count, saturating at 255.
REQ-012 STOP_ON_ERR=1: an error SHALL go to FAIL on the next edge.
REQ-013 When match_count reaches the latched count, the block SHALL go to PASS if err_count==0, else to FAIL.
REQ-014 Latched count 0 SHALL go to PASS one cycle after entering RUN.
REQ-015 The cycle counter SHALL increment every RUN cycle. At TIMEOUT_CYC-1 without completion, the block SHALL go to FAIL with timeout=1.
REQ-016 Completion SHALL take priority over timeout on the same cycle.
REQ-017 A store sampled on the completing cycle SHALL still be evaluated before the PASS/FAIL decision.
REQ-018 PASS and FAIL SHALL hold until start or reset; mem_write SHALL be ignored in PASS, FAIL and IDLE.
REQ-019 Status outputs SHALL update one cycle after the sampling edge.

Reset
REQ-020 reset=0 SHALL immediately force IDLE and clear every output to 0. This includes err_adr/err_data and the hit bits, and applies even in mid-RUN.
REQ-021 Expected-entry storage need not be reset; after reset it SHALL be reloaded before start.
REQ-022 After reset release, the block SHALL stay in IDLE until start.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- ORDERED=1, entry0=(100,7), count=1, start; stores (96,3) then (100,7) -> pass=1 one cycle later, match_count=1, err_count=0.
- Same setup; store (100,8) -> fail=1, err_adr=100, err_data=8, err_count=1, timeout=0.
- STOP_ON_ERR=0, entries (100,7),(104,9); stores (104,9),(100,7),(104,9) -> fail=1 at completion with err_count=1 (the first store is an out-of-order error).
- ORDERED=0, same entries; stores (104,9),(100,7) -> pass=1, match_count=2; in a separate run, a repeated (104,9) before (100,7) -> err_count=1.
- TIMEOUT_CYC=20, count=1, no stores -> fail=1 and timeout=1 exactly 20 cycles after entering RUN.
- reset=0 mid-RUN after one match -> all outputs 0 immediately; start with count=0 -> pass=1 after 2 cycles.
